// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int ITER = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic logic is_div(input op_t op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, with sign fix-up at the end.
// Optional macro MULDIV_FAST_ZERO_EN: a zero operand finishes in 2 cycles.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; latches op, magnitudes and sign flags
// CALC  | 32 shift-add / restoring-divide iterations, one per clock
// FIX   | sign correction and result selection, result registered
// DONE  | done pulse for one cycle, then back to IDLE
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    state_t             state;
    state_t             state_nxt;
    op_t                op_in;
    op_t                op_q;
    logic               sa_in;
    logic               sb_in;
    logic               neg_in;
    logic [WIDTH-1:0]   a_mag_in;
    logic [WIDTH-1:0]   b_mag_in;
    logic [WIDTH-1:0]   opnd_in;
    logic [2*WIDTH-1:0] acc_init;

    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;
    logic [5:0]         cnt;
    logic               neg_q;
    logic               div_zero_q;

    logic               last_iter;
    logic               accept;
    logic               fast_take;
    logic               fast_pend;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ok;
    logic [2*WIDTH-1:0] div_step;

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   fix_res;

    assign op_in     = op_t'(funct3);
    assign last_iter = (cnt == 6'(ITER - 1));
    assign accept    = (state == S_IDLE) && start && !fast_pend;

    // Signedness of the requested op, operand magnitudes and result sign.
    always_comb begin
        sa_in = 1'b0;
        sb_in = 1'b0;
        case (op_in)
            OP_MULH, OP_DIV, OP_REM: begin
                sa_in = rs1[WIDTH-1];
                sb_in = rs2[WIDTH-1];
            end
            OP_MULHSU: sa_in = rs1[WIDTH-1];
            default: ;
        endcase
        a_mag_in = sa_in ? -rs1 : rs1;
        b_mag_in = sb_in ? -rs2 : rs2;
        // The remainder follows the dividend; everything else is sign(a)^sign(b).
        neg_in   = (op_in == OP_REM) ? sa_in : (sa_in ^ sb_in);
        // Multiply: acc low half holds the multiplier, opnd is the multiplicand.
        // Divide: acc low half holds the dividend, opnd is the divisor.
        if (is_div(op_in)) begin
            opnd_in  = b_mag_in;
            acc_init = {{WIDTH{1'b0}}, a_mag_in};
        end else begin
            opnd_in  = a_mag_in;
            acc_init = {{WIDTH{1'b0}}, b_mag_in};
        end
    end

`ifdef MULDIV_FAST_ZERO_EN
    logic [WIDTH-1:0] fast_res;

    assign fast_take = (rs1 == '0) || (rs2 == '0);

    // Closed-form result for a zero operand: product is 0, quotient/remainder
    // follow the divide-by-zero rules or are 0 for a zero dividend.
    always_comb begin
        fast_res = '0;
        if (rs2 == '0) begin
            case (op_in)
                OP_DIV, OP_DIVU: fast_res = {WIDTH{1'b1}};
                OP_REM, OP_REMU: fast_res = rs1;
                default:         fast_res = '0;
            endcase
        end
    end

    // One-cycle hold so the fast done pulse lands two cycles after start.
    always_ff @(posedge clk) begin
        if (rst) begin
            fast_pend <= 1'b0;
        end else begin
            fast_pend <= accept && fast_take;
        end
    end
`else
    assign fast_take = 1'b0;
    assign fast_pend = 1'b0;
`endif

    // One iteration of shift-add multiply and of restoring divide.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_step  = {mul_sum, acc[WIDTH-1:1]};
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_ok    = (div_shift >= {1'b0, opnd});
        div_diff  = div_shift[WIDTH-1:0] - opnd;
        if (div_ok) begin
            div_step = {div_diff, acc[WIDTH-2:0], 1'b1};
        end else begin
            div_step = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
    end

    // Sign correction and result selection applied in FIX.
    always_comb begin
        prod = neg_q ? -acc : acc;
        quo  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem  = neg_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        case (op_q)
            OP_MUL:                      fix_res = prod[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod[2*WIDTH-1:WIDTH];
            // Magnitude divide by zero yields all ones; force it past the negate.
            OP_DIV, OP_DIVU:             fix_res = div_zero_q ? {WIDTH{1'b1}} : quo;
            default:                     fix_res = rem;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (fast_pend) begin
                    state_nxt = S_DONE;
                end else if (accept && !fast_take) begin
                    state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                busy = 1'b1;
                if (last_iter) begin
                    state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                busy      = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= OP_MUL;
            opnd       <= '0;
            acc        <= '0;
            cnt        <= '0;
            neg_q      <= 1'b0;
            div_zero_q <= 1'b0;
            result     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q       <= op_in;
                        opnd       <= opnd_in;
                        acc        <= acc_init;
                        cnt        <= '0;
                        neg_q      <= neg_in;
                        div_zero_q <= (rs2 == '0);
`ifdef MULDIV_FAST_ZERO_EN
                        if (fast_take) begin
                            result <= fast_res;
                        end
`endif
                    end
                end
                S_CALC: begin
                    acc <= is_div(op_q) ? div_step : mul_step;
                    cnt <= (cnt == 6'(ITER)) ? cnt : cnt + 6'd1;
                end
                S_FIX: begin
                    result <= fix_res;
                end
                default: ;
            endcase
        end
    end

endmodule
